int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt controller upstream of the fetch stage of the 8-bit pipelined CPU wrapper.
- Conditions the raw external int_sig pin, latches one pending request, and injects it into the pipeline at a safe boundary.
- On injection: requests a front-end flush, saves the return PC, and redirects fetch to the vector pointer at memory address 8'h01.
- Masks further requests until the handler executes RTI.

Parameters:
- DATA_W, 8, width of PC and address buses.
- VEC_ADDR, 8'h01, memory address holding the handler start address.
- MIN_PULSE, 1, int_sig high cycles (after sync) required to register an edge; range 1..4.

Ports:
- clk  in  1  system clock, rising-edge.
- rstn  in  1  asynchronous active-low reset.
- int_sig  in  1  external interrupt pin, level, may be asynchronous.
- stall_i  in  1  hazard unit stalling fetch/decode this cycle.
- flush_i  in  1  branch/jump flush in progress this cycle.
- pc_i  in  DATA_W  PC of the next instruction to be fetched (return address).
- rti_i  in  1  RTI retiring in writeback this cycle.
- irq_take_o  out  1  one-cycle pulse: pipeline redirects now.
- irq_flush_o  out  1  one-cycle pulse coincident with irq_take_o; flushes IF/ID and ID/EX.
- vec_addr_o  out  DATA_W  address for the vector read; constant VEC_ADDR.
- ret_pc_o  out  DATA_W  saved return PC for the stack push.
- int_active_o  out  1  high from take until RTI retires.
- pending_o  out  1  request latched, not yet taken.

Behaviour:
- Reset (async, rstn=0): state IDLE; irq_take_o=0, irq_flush_o=0, ret_pc_o=0, int_active_o=0, pending_o=0, edge-detector history=0. vec_addr_o=VEC_ADDR at all times.
- Edge detect: a rising edge is registered once int_sig_s (the synchronized or raw signal) has been high MIN_PULSE consecutive cycles after being low. A held-high level gives exactly one edge.
- States:
  - IDLE: an edge moves to PEND and sets pending_o the next cycle.
  - PEND: when stall_i=0 and flush_i=0, go to TAKE. Otherwise hold. Pending is never lost.
  - TAKE (1 cycle): irq_take_o=1, irq_flush_o=1, ret_pc_o<=pc_i captured this cycle, pending_o<=0. Next state SERV with int_active_o=1.
  - SERV: edges are masked and not queued. rti_i=1 returns to IDLE and clears int_active_o the next cycle.
- Latency with INT_SYNC_EN and MIN_PULSE=1, pipeline free: int_sig rises before edge N; edge N+2 sync out high; edge N+3 PEND; edge N+4 TAKE pulse visible; edge N+5 SERV. Without sync, subtract 2.
- Simultaneous edge and rti_i in SERV: the edge is dropped.
- rti_i outside SERV: ignored.
- Edge arriving while PEND: absorbed, single request.
- flush_i and stall_i high in the same cycle: hold.
- ret_pc_o holds its value until the next TAKE.
- Reset mid-TAKE: outputs drop asynchronously; no partial redirect.

Optional Feature:
- INT_SYNC_EN defined: two-flop synchronizer on int_sig (reset to 0) ahead of edge detection.
- INT_SYNC_EN undefined: int_sig feeds edge detection directly, saving 2 cycles of latency. Legal only when int_sig is generated synchronously to clk (testbench use).

Decomposition:
- cpu_pkg: int_state_t (IDLE, PEND, TAKE, SERV; 2-bit encoding), constants INT_VEC_ADDR=8'h01, RESET_VEC_ADDR=8'h00, DATA_W=8.
- Sub-module int_edge_detect: synchronizer (under INT_SYNC_EN), MIN_PULSE counter, single-cycle edge output.

Test Plan:
- Basic take: INT_SYNC_EN on, int_sig high 1 cycle at edge 10, pc_i=8'h05, no stall -> irq_take_o pulse at edge 14, ret_pc_o=8'h05, int_active_o=1 from edge 15.
- Stall defer: edge latched, stall_i high for 3 cycles -> pending_o stays 1; take occurs on the first cycle with stall_i=0, same ret_pc_o capture rule.
- Masking: second int_sig pulse during SERV -> no irq_take_o. After rti_i -> IDLE, int_active_o=0; new pulse is then taken normally.
- Level hold: int_sig held high 20 cycles -> exactly one irq_take_o. After RTI with int_sig still high -> no retake until int_sig goes low then high.
- Flush collision: take candidate in same cycle as flush_i=1 -> take slips one cycle; irq_flush_o never coincides with flush_i.
- Async reset in TAKE: rstn low mid-cycle -> all outputs 0 immediately; after release, state IDLE and pending_o=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the front-end interrupt path.
// Holds int_state_t, bus width and the vector/reset fetch addresses.
package cpu_pkg;

  localparam int DATA_W = 8;

  localparam logic [7:0] INT_VEC_ADDR   = 8'h01;
  localparam logic [7:0] RESET_VEC_ADDR = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    TAKE = 2'd2,
    SERV = 2'd3
  } int_state_t;

endpackage

// File: rtl/int_edge_detect.sv
// Conditions int_sig: optional 2-flop sync (INT_SYNC_EN), then a
// MIN_PULSE high-time qualifier. Ports: clk, rstn, sig_i, edge_o.
module int_edge_detect #(
  parameter int MIN_PULSE = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic sig_i,
  output logic edge_o
);

  localparam logic [2:0] MP = 3'(MIN_PULSE);

  logic       sig_s;
  logic [2:0] cnt;

`ifdef INT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[0], sig_i};
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = sig_i;
`endif

  // cnt saturates at MP, so a held level fires once;
  // only a low sample re-arms the detector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      edge_o <= 1'b0;
    end else if (!sig_s) begin
      cnt    <= '0;
      edge_o <= 1'b0;
    end else if (cnt != MP) begin
      cnt    <= cnt + 3'd1;
      edge_o <= (cnt == MP - 3'd1);
    end else begin
      edge_o <= 1'b0;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller ahead of fetch: latches one request, injects it
// at a stall/flush-free boundary, masks until RTI. Macro: INT_SYNC_EN.
// Ports: clk, rstn, int_sig, stall_i, flush_i, pc_i, rti_i in;
// irq_take_o, irq_flush_o, vec_addr_o, ret_pc_o, int_active_o,
// pending_o out.
module int_ctrl #(
  parameter int                DATA_W    = cpu_pkg::DATA_W,
  parameter logic [DATA_W-1:0] VEC_ADDR  =
    DATA_W'(cpu_pkg::INT_VEC_ADDR),
  parameter int                MIN_PULSE = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              int_sig,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              rti_i,
  output logic              irq_take_o,
  output logic              irq_flush_o,
  output logic [DATA_W-1:0] vec_addr_o,
  output logic [DATA_W-1:0] ret_pc_o,
  output logic              int_active_o,
  output logic              pending_o
);

  import cpu_pkg::*;

  int_state_t state;
  logic       edge_s;

  int_edge_detect #(
    .MIN_PULSE (MIN_PULSE)
  ) u_edge (
    .clk    (clk),
    .rstn   (rstn),
    .sig_i  (int_sig),
    .edge_o (edge_s)
  );

  assign vec_addr_o = VEC_ADDR;

  // ret_pc_o is loaded on entry to TAKE, so it is valid
  // alongside the take pulse for the stack push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      irq_take_o   <= 1'b0;
      irq_flush_o  <= 1'b0;
      ret_pc_o     <= '0;
      int_active_o <= 1'b0;
      pending_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (edge_s) begin
            state     <= PEND;
            pending_o <= 1'b1;
          end
        end
        PEND: begin
          if (!stall_i && !flush_i) begin
            state       <= TAKE;
            irq_take_o  <= 1'b1;
            irq_flush_o <= 1'b1;
            ret_pc_o    <= pc_i;
            pending_o   <= 1'b0;
          end
        end
        TAKE: begin
          state        <= SERV;
          irq_take_o   <= 1'b0;
          irq_flush_o  <= 1'b0;
          int_active_o <= 1'b1;
        end
        SERV: begin
          // Edges here are masked; one coinciding with RTI is dropped.
          if (rti_i) begin
            state        <= IDLE;
            int_active_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
// Latency adapts to whether INT_SYNC_EN is defined.
module tb_int_ctrl;

`ifdef INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       int_sig;
  logic       stall_i;
  logic       flush_i;
  logic [7:0] pc_i;
  logic       rti_i;
  logic       irq_take_o;
  logic       irq_flush_o;
  logic [7:0] vec_addr_o;
  logic [7:0] ret_pc_o;
  logic       int_active_o;
  logic       pending_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .int_sig      (int_sig),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .pc_i         (pc_i),
    .rti_i        (rti_i),
    .irq_take_o   (irq_take_o),
    .irq_flush_o  (irq_flush_o),
    .vec_addr_o   (vec_addr_o),
    .ret_pc_o     (ret_pc_o),
    .int_active_o (int_active_o),
    .pending_o    (pending_o)
  );

  task automatic step;
    @(negedge clk);
  endtask

  // One-cycle pulse; returns once the qualified edge is registered.
  task automatic pulse;
    int_sig = 1'b1;
    step();
    int_sig = 1'b0;
    repeat (SYNC_LAT) step();
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({irq_take_o, irq_flush_o, int_active_o, pending_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000",
        {irq_take_o, irq_flush_o, int_active_o, pending_o});
    end
    checks++;
    if (ret_pc_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_ret_pc got %h exp 00", ret_pc_o);
    end
    checks++;
    if (vec_addr_o !== 8'h01) begin
      errors++;
      $display("FAIL vec_addr got %h exp 01", vec_addr_o);
    end
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic_take;
    pc_i = 8'h05;
    pulse();
    checks++;
    if (pending_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_pend got %b exp 0", pending_o);
    end
    step();
    checks++;
    if ({pending_o, irq_take_o} !== 2'b10) begin
      errors++;
      $display("FAIL basic_pend got %b exp 10", {pending_o, irq_take_o});
    end
    step();
    checks++;
    if ({irq_take_o, irq_flush_o, pending_o, int_active_o} !== 4'b1100) begin
      errors++;
      $display("FAIL basic_take got %b exp 1100",
        {irq_take_o, irq_flush_o, pending_o, int_active_o});
    end
    checks++;
    if (ret_pc_o !== 8'h05) begin
      errors++;
      $display("FAIL basic_ret_pc got %h exp 05", ret_pc_o);
    end
    step();
    checks++;
    if ({irq_take_o, irq_flush_o, int_active_o} !== 3'b001) begin
      errors++;
      $display("FAIL basic_serv got %b exp 001",
        {irq_take_o, irq_flush_o, int_active_o});
    end
    rti_i = 1'b1;
    step();
    rti_i = 1'b0;
    checks++;
    if (int_active_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_rti got %b exp 0", int_active_o);
    end
  endtask

  task automatic test_stall_defer;
    int n;
    stall_i = 1'b1;
    pc_i = 8'h10;
    pulse();
    step();
    checks++;
    if ({pending_o, irq_take_o} !== 2'b10) begin
      errors++;
      $display("FAIL stall_pend got %b exp 10", {pending_o, irq_take_o});
    end
    pc_i = 8'h11;
    pulse();
    step();
    pc_i = 8'h12;
    step();
    checks++;
    if ({pending_o, irq_take_o} !== 2'b10) begin
      errors++;
      $display("FAIL stall_hold got %b exp 10", {pending_o, irq_take_o});
    end
    pc_i = 8'h33;
    stall_i = 1'b0;
    step();
    checks++;
    if ({irq_take_o, pending_o} !== 2'b10) begin
      errors++;
      $display("FAIL stall_take got %b exp 10", {irq_take_o, pending_o});
    end
    checks++;
    if (ret_pc_o !== 8'h33) begin
      errors++;
      $display("FAIL stall_ret_pc got %h exp 33", ret_pc_o);
    end
    pc_i = 8'h34;
    n = 0;
    repeat (3) begin
      step();
      if (irq_take_o) n++;
    end
    rti_i = 1'b1;
    step();
    rti_i = 1'b0;
    repeat (4) begin
      step();
      if (irq_take_o || pending_o) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL stall_absorb extra events %0d exp 0", n);
    end
    checks++;
    if (ret_pc_o !== 8'h33) begin
      errors++;
      $display("FAIL stall_ret_hold got %h exp 33", ret_pc_o);
    end
  endtask

  task automatic test_masking;
    int n;
    pc_i = 8'h40;
    pulse();
    step();
    step();
    step();
    checks++;
    if (int_active_o !== 1'b1) begin
      errors++;
      $display("FAIL mask_active got %b exp 1", int_active_o);
    end
    pulse();
    n = 0;
    repeat (4) begin
      step();
      if (irq_take_o || pending_o) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL mask_serv events %0d exp 0", n);
    end
    rti_i = 1'b1;
    step();
    rti_i = 1'b0;
    checks++;
    if (int_active_o !== 1'b0) begin
      errors++;
      $display("FAIL mask_rti got %b exp 0", int_active_o);
    end
    pc_i = 8'h44;
    pulse();
    step();
    step();
    step();
    pulse();
    rti_i = 1'b1;
    step();
    rti_i = 1'b0;
    n = 0;
    repeat (4) begin
      step();
      if (irq_take_o || pending_o || int_active_o) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL mask_edge_rti events %0d exp 0", n);
    end
    rti_i = 1'b1;
    step();
    rti_i = 1'b0;
    checks++;
    if ({irq_take_o, pending_o, int_active_o} !== 3'b000) begin
      errors++;
      $display("FAIL rti_idle got %b exp 000",
        {irq_take_o, pending_o, int_active_o});
    end
    pc_i = 8'h55;
    pulse();
    step();
    step();
    checks++;
    if ({irq_take_o, ret_pc_o} !== {1'b1, 8'h55}) begin
      errors++;
      $display("FAIL mask_retake got %b/%h exp 1/55", irq_take_o, ret_pc_o);
    end
    step();
    rti_i = 1'b1;
    step();
    rti_i = 1'b0;
  endtask

  task automatic test_level_hold;
    int n;
    pc_i = 8'h60;
    int_sig = 1'b1;
    n = 0;
    repeat (20) begin
      step();
      if (irq_take_o) n++;
    end
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL level_takes got %0d exp 1", n);
    end
    rti_i = 1'b1;
    step();
    rti_i = 1'b0;
    n = 0;
    repeat (8) begin
      step();
      if (irq_take_o || pending_o) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL level_retake events %0d exp 0", n);
    end
    int_sig = 1'b0;
    step();
    pc_i = 8'h61;
    pulse();
    step();
    step();
    checks++;
    if ({irq_take_o, ret_pc_o} !== {1'b1, 8'h61}) begin
      errors++;
      $display("FAIL level_rearm got %b/%h exp 1/61", irq_take_o, ret_pc_o);
    end
    step();
    rti_i = 1'b1;
    step();
    rti_i = 1'b0;
  endtask

  task automatic test_flush_collision;
    pc_i = 8'h70;
    pulse();
    step();
    flush_i = 1'b1;
    step();
    checks++;
    if ({irq_take_o, irq_flush_o, pending_o} !== 3'b001) begin
      errors++;
      $display("FAIL flush_slip got %b exp 001",
        {irq_take_o, irq_flush_o, pending_o});
    end
    stall_i = 1'b1;
    step();
    checks++;
    if ({irq_take_o, irq_flush_o, pending_o} !== 3'b001) begin
      errors++;
      $display("FAIL flush_stall_hold got %b exp 001",
        {irq_take_o, irq_flush_o, pending_o});
    end
    stall_i = 1'b0;
    flush_i = 1'b0;
    step();
    checks++;
    if ({irq_take_o, irq_flush_o, ret_pc_o} !== {2'b11, 8'h70}) begin
      errors++;
      $display("FAIL flush_take got %b%b/%h exp 11/70",
        irq_take_o, irq_flush_o, ret_pc_o);
    end
    step();
    rti_i = 1'b1;
    step();
    rti_i = 1'b0;
  endtask

  task automatic test_reset_in_take;
    pc_i = 8'h80;
    pulse();
    step();
    step();
    checks++;
    if (irq_take_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_take got %b exp 1", irq_take_o);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({irq_take_o, irq_flush_o, pending_o, int_active_o, ret_pc_o}
        !== 12'h000) begin
      errors++;
      $display("FAIL rst_async got %b%b%b%b/%h exp 0000/00",
        irq_take_o, irq_flush_o, pending_o, int_active_o, ret_pc_o);
    end
    step();
    rstn = 1'b1;
    step();
    checks++;
    if ({irq_take_o, pending_o, int_active_o} !== 3'b000) begin
      errors++;
      $display("FAIL rst_release got %b exp 000",
        {irq_take_o, pending_o, int_active_o});
    end
    pc_i = 8'h81;
    pulse();
    step();
    step();
    checks++;
    if ({irq_take_o, ret_pc_o} !== {1'b1, 8'h81}) begin
      errors++;
      $display("FAIL rst_retake got %b/%h exp 1/81", irq_take_o, ret_pc_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int_sig = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    rti_i   = 1'b0;
    pc_i    = 8'h00;
    test_reset();
    test_basic_take();
    test_stall_defer();
    test_masking();
    test_level_hold();
    test_flush_collision();
    test_reset_in_take();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
